// File: rtl/dpram_read_streamer_pkg.sv
// Shared types and width helpers for the dual-port RAM read streamer.
package dpram_read_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

  localparam int unsigned DEF_ADDR_WIDTH    = 4;
  localparam int unsigned DEF_DATA_WIDTH    = 8;
  localparam int unsigned DEF_READ_LANTENCY = 3;
  localparam int unsigned DEF_FIFO_DEPTH    = 4;

  // Bits needed to hold a count in the range 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index `depth` entries (at least one bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dpram_read_streamer_if.sv
// Control, RAM-port and stream signals of the read streamer.
interface dpram_read_streamer_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  i_start;
  logic [ADDR_WIDTH-1:0] i_base_addr;
  logic [ADDR_WIDTH:0]   i_len;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_ram_en;
  logic                  o_ram_we;
  logic [ADDR_WIDTH-1:0] o_ram_addr;
  logic [DATA_WIDTH-1:0] o_ram_din;
  logic [DATA_WIDTH-1:0] i_ram_dout;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_last;
  logic                  i_ready;

  modport master (
    input  i_start, i_base_addr, i_len, i_ram_dout, i_ready,
    output o_busy, o_done, o_ram_en, o_ram_we, o_ram_addr, o_ram_din,
           o_data, o_valid, o_last
  );

  modport slave (
    output i_start, i_base_addr, i_len, i_ram_dout, i_ready,
    input  o_busy, o_done, o_ram_en, o_ram_we, o_ram_addr, o_ram_din,
           o_data, o_valid, o_last
  );
endinterface

// File: rtl/dpram_read_streamer_fifo.sv
// Show-ahead FIFO with occupancy count; push while full is accepted when a pop
// happens in the same cycle.
module sync_fifo_fwft
  import dpram_read_streamer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_empty,
  output logic [cnt_width(DEPTH)-1:0]  o_count
);
  localparam int unsigned PW = idx_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             full, push_ok, pop_ok;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign o_empty = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_push & (~full | pop_ok);
  assign o_data  = mem_q[rd_q];
  assign o_count = cnt_q;

  // Storage, pointers and occupancy count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= i_data;
        wr_q        <= bump(wr_q);
      end
      if (pop_ok) rd_q <= bump(rd_q);
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + CW'(1);
      else if (!push_ok && pop_ok) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/dpram_read_streamer.sv
// Burst reader for one RAM port: issues reads under FIFO credit, tracks them
// through the fixed RAM latency and streams the words out on valid/ready.
module dpram_read_streamer
  import dpram_read_streamer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned READ_LANTENCY = DEF_READ_LANTENCY,
  parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  dpram_read_streamer_if.master bus
);
  localparam int unsigned FCW = cnt_width(FIFO_DEPTH);
  localparam int unsigned CW  = cnt_width(FIFO_DEPTH + READ_LANTENCY);
  localparam int unsigned FW  = DATA_WIDTH + 1;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    cur_q, cur_d;
  logic [ADDR_WIDTH:0]      rem_q, rem_d;
  logic                     zdone_q, zdone_d;
  logic [READ_LANTENCY-1:0] trk_q, trk_d, trk_last_q, trk_last_d;
  logic                     issue, drain_done, credit, pop, fifo_empty;
  logic [FCW-1:0]           fifo_cnt;
  logic [CW-1:0]            inflight, occupancy;
  logic [FW-1:0]            fifo_head;

  sync_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (trk_q[READ_LANTENCY-1]),
    .i_data  ({trk_last_q[READ_LANTENCY-1], bus.i_ram_dout}),
    .i_pop   (pop),
    .o_data  (fifo_head),
    .o_empty (fifo_empty),
    .o_count (fifo_cnt)
  );

  assign pop = ~fifo_empty & bus.i_ready;

  // Credit: reads in flight plus buffered words, less a word leaving now.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < READ_LANTENCY; i++) inflight = inflight + CW'(trk_q[i]);
    occupancy = inflight + CW'(fifo_cnt) - CW'(pop);
    credit    = (occupancy < CW'(FIFO_DEPTH));
  end

  // Burst FSM next state, address/remaining counters and issue decision.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    zdone_d    = 1'b0;
    issue      = 1'b0;
    drain_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_len != '0) begin
            cur_d   = bus.i_base_addr;
            rem_d   = bus.i_len;
            state_d = ST_ISSUE;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (credit) begin
          issue = 1'b1;
          cur_d = cur_q + ADDR_WIDTH'(1);
          rem_d = rem_q - (ADDR_WIDTH + 1)'(1);
          if (rem_q == (ADDR_WIDTH + 1)'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (trk_q == '0 && fifo_empty) begin
          drain_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // In-flight tracker: one issue bit (and last tag) per RAM latency stage.
  always_comb begin
    trk_d         = '0;
    trk_last_d    = '0;
    trk_d[0]      = issue;
    trk_last_d[0] = issue & (rem_q == (ADDR_WIDTH + 1)'(1));
    for (int unsigned i = 1; i < READ_LANTENCY; i++) begin
      trk_d[i]      = trk_q[i-1];
      trk_last_d[i] = trk_last_q[i-1];
    end
  end

  // State, counters and tracker registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      rem_q      <= '0;
      zdone_q    <= 1'b0;
      trk_q      <= '0;
      trk_last_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      zdone_q    <= zdone_d;
      trk_q      <= trk_d;
      trk_last_q <= trk_last_d;
    end
  end

  assign bus.o_ram_en   = issue;
  assign bus.o_ram_we   = 1'b0;
  assign bus.o_ram_addr = cur_q;
  assign bus.o_ram_din  = '0;
  assign bus.o_done     = zdone_q | drain_done;
  assign bus.o_busy     = (state_q != ST_IDLE) & ~drain_done;
  assign bus.o_valid    = ~fifo_empty;
  assign bus.o_data     = fifo_head[DATA_WIDTH-1:0];
  assign bus.o_last     = ~fifo_empty & fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_dpram_read_streamer.sv
// Directed bench with a word/address scoreboard for dpram_read_streamer.
module tb_dpram_read_streamer;
  localparam int RL = 3;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  dpram_read_streamer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  dpram_read_streamer #(
    .ADDR_WIDTH    (4),
    .DATA_WIDTH    (8),
    .READ_LANTENCY (RL),
    .FIFO_DEPTH    (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // RAM model: mem[a] = a + 0x10, RL-cycle read latency.
  logic [7:0] ram [16];
  logic [7:0] rd_pipe [RL];
  initial for (int a = 0; a < 16; a++) ram[a] = 8'(a) + 8'h10;
  always @(posedge clk) begin
    if (bus.o_ram_en && !bus.o_ram_we) rd_pipe[0] <= ram[bus.o_ram_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.i_ram_dout = rd_pipe[RL-1];

  logic [8:0] exp_q[$];
  logic [3:0] addr_q[$];
  int  en_cnt = 0, xfer_cnt = 0, done_cnt = 0, issued = 0, max_out = 0;
  int  first_valid_cyc = 0, ts = 0;
  bit  seen_valid = 1'b0;
  bit  stall_q = 1'b0;
  logic [7:0] stall_data;
  logic       stall_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: address order, word order, hold under stall, credit bound.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (bus.o_ram_en) begin
        en_cnt++;
        issued++;
        if (addr_q.size() == 0) chk("ram_addr_extra", 32'(1), 32'(0));
        else chk("ram_addr", 32'(bus.o_ram_addr), 32'(addr_q.pop_front()));
      end
      if (bus.o_valid && !seen_valid) begin
        seen_valid      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (stall_q) begin
        chk("hold_valid", 32'(bus.o_valid), 32'(1));
        chk("hold_data", 32'(bus.o_data), 32'(stall_data));
        chk("hold_last", 32'(bus.o_last), 32'(stall_last));
      end
      if (bus.o_valid && bus.i_ready) begin
        logic [8:0] e;
        xfer_cnt++;
        if (exp_q.size() == 0) chk("word_extra", 32'(1), 32'(0));
        else begin
          e = exp_q.pop_front();
          chk("data", 32'(bus.o_data), 32'(e[7:0]));
          chk("last", 32'(bus.o_last), 32'(e[8]));
        end
      end
      stall_q    = bus.o_valid && !bus.i_ready;
      stall_data = bus.o_data;
      stall_last = bus.o_last;
      if (bus.o_done) done_cnt++;
      if (issued - xfer_cnt > max_out) max_out = issued - xfer_cnt;
    end
  end

  task automatic start_burst(input logic [3:0] base, input logic [4:0] len, input bit expect_it);
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_base_addr = base;
    bus.i_len       = len;
    if (expect_it) begin
      seen_valid = 1'b0;
      for (int k = 0; k < int'(len); k++) begin
        logic [3:0] a;
        logic [7:0] d;
        a = base + 4'(k);
        d = {4'h0, a} + 8'h10;
        exp_q.push_back({k == int'(len) - 1, d});
        addr_q.push_back(a);
      end
    end
    @(negedge clk);
    ts          = cyc;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt >= target) break;
    end
    chk("done_reached", 32'(done_cnt >= target), 32'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'(0));
    chk({tag, "_done"}, 32'(bus.o_done), 32'(0));
    chk({tag, "_ram_en"}, 32'(bus.o_ram_en), 32'(0));
    chk({tag, "_ram_addr"}, 32'(bus.o_ram_addr), 32'(0));
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'(0));
    chk({tag, "_last"}, 32'(bus.o_last), 32'(0));
    chk({tag, "_data"}, 32'(bus.o_data), 32'(0));
  endtask

  initial begin
    int e0, d0, x0;
    rst_n           = 1'b0;
    bus.i_start     = 1'b0;
    bus.i_base_addr = '0;
    bus.i_len       = '0;
    bus.i_ready     = 1'b1;
    #12;
    chk_all_zero("reset");
    chk("reset_we", 32'(bus.o_ram_we), 32'(0));
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;

    // 1: base 2, len 4, full throughput
    e0 = en_cnt; d0 = done_cnt;
    start_burst(4'd2, 5'd4, 1'b1);
    #2 chk("t1_busy", 32'(bus.o_busy), 32'(1));
    wait_done(d0 + 1, 40);
    chk("t1_first_valid", 32'(first_valid_cyc), 32'(ts + 4));
    chk("t1_en_count", 32'(en_cnt - e0), 32'(4));
    chk("t1_words_left", 32'(exp_q.size()), 32'(0));
    chk("t1_busy_at_done", 32'(bus.o_busy), 32'(0));

    // 2: address wrap 14,15,0,1
    @(negedge clk);
    e0 = en_cnt; d0 = done_cnt;
    start_burst(4'd14, 5'd4, 1'b1);
    wait_done(d0 + 1, 40);
    chk("t2_en_count", 32'(en_cnt - e0), 32'(4));
    chk("t2_words_left", 32'(exp_q.size()), 32'(0));

    // 3: full 16-word burst with a 10-cycle stall
    @(negedge clk);
    d0 = done_cnt; max_out = 0;
    start_burst(4'd0, 5'd16, 1'b1);
    repeat (5) @(negedge clk);
    bus.i_ready = 1'b0;
    repeat (10) @(negedge clk);
    bus.i_ready = 1'b1;
    wait_done(d0 + 1, 80);
    chk("t3_credit_bound", 32'(max_out <= 4), 32'(1));
    chk("t3_words_left", 32'(exp_q.size()), 32'(0));
    repeat (3) @(negedge clk);
    chk("t3_single_done", 32'(done_cnt - d0), 32'(1));

    // 4: zero-length burst
    e0 = en_cnt; d0 = done_cnt;
    start_burst(4'd7, 5'd0, 1'b1);
    #2 chk("t4_done_pulse", 32'(bus.o_done), 32'(1));
    chk("t4_busy", 32'(bus.o_busy), 32'(0));
    @(negedge clk);
    #2 chk("t4_done_low", 32'(bus.o_done), 32'(0));
    repeat (4) @(negedge clk);
    chk("t4_no_ram", 32'(en_cnt - e0), 32'(0));
    chk("t4_no_valid", 32'(seen_valid), 32'(0));
    chk("t4_done_count", 32'(done_cnt - d0), 32'(1));

    // 5: reset after three words, then a fresh burst
    x0 = xfer_cnt;
    start_burst(4'd0, 5'd8, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (xfer_cnt - x0 >= 3) break;
    end
    chk("t5_three_words", 32'(xfer_cnt - x0 >= 3), 32'(1));
    rst_n = 1'b0;
    #1 chk_all_zero("t5_abort");
    exp_q.delete();
    addr_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_no_done", 32'(done_cnt - d0), 32'(0));
    issued = 0; xfer_cnt = 0;
    start_burst(4'd5, 5'd2, 1'b1);
    wait_done(d0 + 1, 40);
    chk("t5_words_left", 32'(exp_q.size()), 32'(0));

    // 6: start while busy is ignored
    @(negedge clk);
    e0 = en_cnt; d0 = done_cnt;
    start_burst(4'd3, 5'd5, 1'b1);
    start_burst(4'd9, 5'd2, 1'b0);
    wait_done(d0 + 1, 40);
    repeat (6) @(negedge clk);
    chk("t6_en_count", 32'(en_cnt - e0), 32'(5));
    chk("t6_words_left", 32'(exp_q.size()), 32'(0));
    chk("t6_done_count", 32'(done_cnt - d0), 32'(1));
    chk("t6_idle", 32'(bus.o_busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
